// File: rtl/dispatch_wide.sv
// dispatch_wide: in-order multi-lane dispatch stage for the eZ90 core.
// A circular FIFO buffers renamed uops. Each cycle up to WIDTH uops leave from
// the head in program order. They get contiguous ROB indices and are routed to
// the RS or the LSQ under per-target credit limits. Outputs are
// fire-and-forget: downstream must honour the credits it advertised.
// Optional feature: define EZ90_DISPATCH_BYPASS_EN to present an incoming uop
// as slot 0 in the same cycle when the FIFO is empty.
module dispatch_wide #(
  parameter int unsigned WIDTH     = 2,
  parameter int unsigned QDEPTH    = 8,
  parameter int unsigned UOP_W     = 64,
  parameter int unsigned ROB_IDX_W = 6,
  parameter int unsigned CW        = $clog2(WIDTH + 1)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic                                  in_valid,
  input  logic [UOP_W-1:0]                      in_uop,
  input  logic                                  in_to_lsq,
  output logic                                  in_ready,
  input  logic [ROB_IDX_W:0]                    rob_free,
  input  logic [ROB_IDX_W-1:0]                  rob_tail_idx,
  output logic [CW-1:0]                         rob_alloc_count,
  output logic [WIDTH*UOP_W-1:0]                rob_alloc_uop,
  input  logic [CW-1:0]                         rs_avail,
  output logic [WIDTH-1:0]                      rs_valid,
  output logic [WIDTH*(ROB_IDX_W+UOP_W)-1:0]    rs_uop,
  input  logic [CW-1:0]                         lsq_avail,
  output logic [WIDTH-1:0]                      lsq_valid,
  output logic [WIDTH*(ROB_IDX_W+UOP_W)-1:0]    lsq_uop,
  output logic [$clog2(QDEPTH+1)-1:0]           occupancy
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned OW = $clog2(QDEPTH + 1);
  localparam int unsigned EW = ROB_IDX_W + UOP_W;

  // FIFO storage and pointers
  logic [UOP_W-1:0] mem_uop [QDEPTH];
  logic [QDEPTH-1:0] mem_lsq;
  logic [PW-1:0]     head_q;
  logic [PW-1:0]     tail_q;
  logic [OW-1:0]     count_q;

  // Head window as seen by the dispatch logic
  logic [UOP_W-1:0] slot_uop [WIDTH];
  logic [WIDTH-1:0] slot_lsq;
  logic [WIDTH-1:0] slot_avail;
  logic [WIDTH-1:0] disp;

  logic [CW-1:0] n;
  logic [CW-1:0] n_fifo;
  logic          byp_act;
  logic          byp_taken;
  logic          enq;

  assign in_ready  = (count_q != OW'(QDEPTH)) && !rst;
  assign occupancy = count_q;

`ifdef EZ90_DISPATCH_BYPASS_EN
  // An empty FIFO lets the offered uop compete as slot 0 this cycle.
  assign byp_act   = (count_q == '0) && in_valid && !flush && !rst;
  assign byp_taken = byp_act && disp[0];
`else
  assign byp_act   = 1'b0;
  assign byp_taken = 1'b0;
`endif

  // A bypassed uop never occupied a FIFO entry, so it must not move the head.
  assign n_fifo = n - CW'(byp_taken);
  assign enq    = in_valid && in_ready && !flush && !byp_taken;

  // Gather the WIDTH oldest entries (or the bypassed uop) into slots.
  always_comb begin
    logic [PW-1:0] idx;
    idx = '0;
    for (int k = 0; k < WIDTH; k++) begin
      idx           = head_q + PW'(k);
      slot_uop[k]   = mem_uop[idx];
      slot_lsq[k]   = mem_lsq[idx];
      slot_avail[k] = (k < int'(count_q));
    end
    if (byp_act) begin
      slot_uop[0]   = in_uop;
      slot_lsq[0]   = in_to_lsq;
      slot_avail[0] = 1'b1;
    end
  end

  // Select dispatching slots in order, then pack them per target.
  always_comb begin
    logic                 go;
    logic [CW-1:0]        rs_n;
    logic [CW-1:0]        lsq_n;
    logic [ROB_IDX_W-1:0] rob_idx;
    go            = !rst && !flush;
    rs_n          = '0;
    lsq_n         = '0;
    rob_idx       = '0;
    n             = '0;
    disp          = '0;
    rob_alloc_uop = '0;
    rs_valid      = '0;
    rs_uop        = '0;
    lsq_valid     = '0;
    lsq_uop       = '0;
    for (int k = 0; k < WIDTH; k++) begin
      // Once a slot fails, go stays low and blocks every younger slot.
      go = go && slot_avail[k] && (k < int'(rob_free));
      if (slot_lsq[k]) begin
        go = go && (int'(lsq_n) + 1 <= int'(lsq_avail));
      end else begin
        go = go && (int'(rs_n) + 1 <= int'(rs_avail));
      end
      if (go) begin
        disp[k] = 1'b1;
        rob_idx = rob_tail_idx + ROB_IDX_W'(k);
        rob_alloc_uop[k*UOP_W +: UOP_W] = slot_uop[k];
        if (slot_lsq[k]) begin
          lsq_valid = lsq_valid | (WIDTH'(1) << lsq_n);
          lsq_uop[int'(lsq_n)*EW +: EW] = {rob_idx, slot_uop[k]};
          lsq_n = lsq_n + CW'(1);
        end else begin
          rs_valid = rs_valid | (WIDTH'(1) << rs_n);
          rs_uop[int'(rs_n)*EW +: EW] = {rob_idx, slot_uop[k]};
          rs_n = rs_n + CW'(1);
        end
        n = n + CW'(1);
      end
    end
  end

  assign rob_alloc_count = n;

  // Pointer and count update; reset beats flush, flush beats enqueue/dispatch.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + PW'(n_fifo);
      tail_q  <= tail_q + PW'(enq);
      count_q <= count_q + OW'(enq) - OW'(n_fifo);
    end
  end

  // Payload write at the tail; storage needs no reset since count gates reads.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_uop[tail_q] <= in_uop;
      mem_lsq[tail_q] <= in_to_lsq;
    end
  end

endmodule

// File: tb/tb_dispatch_wide.sv
// Bench for dispatch_wide: table of per-cycle vectors with hand-computed
// expectations, plus hand-written latency and reset-priority sequences.
module tb_dispatch_wide;

  localparam int WIDTH = 2;
  localparam int QDEPTH = 8;
  localparam int UOP_W = 64;
  localparam int RIW = 6;
  localparam int CW = 2;
  localparam int EW = RIW + UOP_W;

  logic                 clk = 1'b0;
  logic                 rst, flush, in_valid, in_to_lsq, in_ready;
  logic [UOP_W-1:0]     in_uop;
  logic [RIW:0]         rob_free;
  logic [RIW-1:0]       rob_tail_idx;
  logic [CW-1:0]        rob_alloc_count, rs_avail, lsq_avail;
  logic [WIDTH*UOP_W-1:0] rob_alloc_uop;
  logic [WIDTH-1:0]     rs_valid, lsq_valid;
  logic [WIDTH*EW-1:0]  rs_uop, lsq_uop;
  logic [3:0]           occupancy;

  always #5 clk = ~clk;

  dispatch_wide #(
    .WIDTH(WIDTH), .QDEPTH(QDEPTH), .UOP_W(UOP_W), .ROB_IDX_W(RIW), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_uop(in_uop),
    .in_to_lsq(in_to_lsq), .in_ready(in_ready), .rob_free(rob_free),
    .rob_tail_idx(rob_tail_idx), .rob_alloc_count(rob_alloc_count),
    .rob_alloc_uop(rob_alloc_uop), .rs_avail(rs_avail), .rs_valid(rs_valid),
    .rs_uop(rs_uop), .lsq_avail(lsq_avail), .lsq_valid(lsq_valid),
    .lsq_uop(lsq_uop), .occupancy(occupancy)
  );

  typedef struct {
    logic       rst, fl, iv;
    logic [7:0] tag;
    logic       lsq;
    logic [6:0] rf;
    logic [5:0] tail;
    logic [1:0] rs_av, lq_av;
    logic       e_rdy;
    logic [1:0] e_n;
    logic [7:0] e_t0;
    logic       e_l0;
    logic [7:0] e_t1;
    logic       e_l1;
    logic [3:0] e_occ;
  } vec_t;

  vec_t tbl[$];
  int   n_chk = 0;
  int   n_fail = 0;

`ifdef EZ90_DISPATCH_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  function automatic vec_t mk(int r, int f, int iv, int tag, int l, int rf, int tail, int rs,
                              int lq, int rdy, int n, int t0, int l0, int t1, int l1, int occ);
    vec_t v;
    v.rst = 1'(r); v.fl = 1'(f); v.iv = 1'(iv); v.tag = 8'(tag); v.lsq = 1'(l);
    v.rf = 7'(rf); v.tail = 6'(tail); v.rs_av = 2'(rs); v.lq_av = 2'(lq);
    v.e_rdy = 1'(rdy); v.e_n = 2'(n); v.e_t0 = 8'(t0); v.e_l0 = 1'(l0);
    v.e_t1 = 8'(t1); v.e_l1 = 1'(l1); v.e_occ = 4'(occ);
    return v;
  endfunction

  function automatic logic [UOP_W-1:0] uop_of(logic [7:0] tag);
    return {56'hC0FFEE12345678, tag};
  endfunction

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic iv, input logic [7:0] tag,
                       input logic l, input int rf, input int tail, input int rs, input int lq);
    rst = r; flush = f; in_valid = iv; in_uop = uop_of(tag); in_to_lsq = l;
    rob_free = 7'(rf); rob_tail_idx = 6'(tail); rs_avail = 2'(rs); lsq_avail = 2'(lq);
  endtask

  initial begin
    logic [WIDTH*UOP_W-1:0] e_al;
    logic [WIDTH*EW-1:0]    e_rs, e_lq;
    logic [WIDTH-1:0]       e_rsv, e_lqv;
    logic [UOP_W-1:0]       u;
    logic [RIW-1:0]         idx;
    logic [7:0]             t;
    logic                   l;
    int                     rj, lj;

    // Reset for two cycles, then one RS uop with all credits
    tbl.push_back(mk(1,0,0,0,0, 64,0,2,2,  0,0,0,0,0,0, 0));
    tbl.push_back(mk(1,0,0,0,0, 64,0,2,2,  0,0,0,0,0,0, 0));
    tbl.push_back(mk(0,0,1,8'h01,0, 64,5,2,2,  1,BYP,BYP,0,0,0, 0));
    tbl.push_back(mk(0,0,0,0,0, 64,5,2,2,  1,1-BYP,1-BYP,0,0,0, 1-BYP));
    tbl.push_back(mk(0,0,0,0,0, 64,5,2,2,  1,0,0,0,0,0, 0));
    // Mixed dual dispatch with ROB index wrap
    tbl.push_back(mk(0,0,1,8'h02,0, 64,63,0,0,  1,0,0,0,0,0, 0));
    tbl.push_back(mk(0,0,1,8'h03,1, 64,63,0,0,  1,0,0,0,0,0, 1));
    tbl.push_back(mk(0,0,0,0,0, 64,63,1,1,  1,2,8'h02,0,8'h03,1, 2));
    // Older LSQ uop without credit blocks the younger RS uop
    tbl.push_back(mk(0,0,1,8'h04,1, 64,10,0,0,  1,0,0,0,0,0, 0));
    tbl.push_back(mk(0,0,1,8'h05,0, 64,10,2,0,  1,0,0,0,0,0, 1));
    tbl.push_back(mk(0,0,0,0,0, 64,10,2,0,  1,0,0,0,0,0, 2));
    tbl.push_back(mk(0,0,0,0,0, 64,10,2,1,  1,2,8'h04,1,8'h05,0, 2));
    // ROB free-space limit
    tbl.push_back(mk(0,0,1,8'h06,0, 0,20,2,2,  1,0,0,0,0,0, 0));
    tbl.push_back(mk(0,0,1,8'h07,0, 0,20,2,2,  1,0,0,0,0,0, 1));
    tbl.push_back(mk(0,0,0,0,0, 1,20,2,2,  1,1,8'h06,0,0,0, 2));
    tbl.push_back(mk(0,0,0,0,0, 64,21,2,2,  1,1,8'h07,0,0,0, 1));
    tbl.push_back(mk(0,0,0,0,0, 64,22,2,2,  1,0,0,0,0,0, 0));
    // Fill to full, offer while full, then drain two per cycle
    for (int i = 0; i < 8; i++) tbl.push_back(mk(0,0,1,8'h10+i,i%2, 64,0,0,0, 1,0,0,0,0,0, i));
    tbl.push_back(mk(0,0,1,8'h18,0, 64,0,0,0,  0,0,0,0,0,0, 8));
    for (int j = 0; j < 4; j++)
      tbl.push_back(mk(0,0,0,0,0, 64,30+2*j,2,2, (j != 0), 2,8'h10+2*j,0,8'h11+2*j,1, 8-2*j));
    tbl.push_back(mk(0,0,0,0,0, 64,38,2,2,  1,0,0,0,0,0, 0));
    // Flush with an offered uop and credits available
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0,0,1,8'h20+i,0, 64,0,0,0, 1,0,0,0,0,0, i));
    tbl.push_back(mk(0,1,1,8'h25,0, 64,40,2,2,  1,0,0,0,0,0, 5));
    tbl.push_back(mk(0,0,0,0,0, 64,40,2,2,  1,0,0,0,0,0, 0));

    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 64, 0, 2, 2);
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].fl, tbl[i].iv, tbl[i].tag, tbl[i].lsq, int'(tbl[i].rf),
            int'(tbl[i].tail), int'(tbl[i].rs_av), int'(tbl[i].lq_av));
      #2;
      e_al = '0; e_rs = '0; e_lq = '0; e_rsv = '0; e_lqv = '0; rj = 0; lj = 0;
      for (int k = 0; k < int'(tbl[i].e_n); k++) begin
        t   = (k == 0) ? tbl[i].e_t0 : tbl[i].e_t1;
        l   = (k == 0) ? tbl[i].e_l0 : tbl[i].e_l1;
        u   = uop_of(t);
        idx = tbl[i].tail + 6'(k);
        e_al[k*UOP_W +: UOP_W] = u;
        if (l) begin
          e_lq[lj*EW +: EW] = {idx, u}; e_lqv[lj] = 1'b1; lj++;
        end else begin
          e_rs[rj*EW +: EW] = {idx, u}; e_rsv[rj] = 1'b1; rj++;
        end
      end
      check($sformatf("row%0d in_ready", i), 256'(in_ready), 256'(tbl[i].e_rdy));
      check($sformatf("row%0d occupancy", i), 256'(occupancy), 256'(tbl[i].e_occ));
      check($sformatf("row%0d rob_alloc_count", i), 256'(rob_alloc_count), 256'(tbl[i].e_n));
      check($sformatf("row%0d rob_alloc_uop", i), 256'(rob_alloc_uop), 256'(e_al));
      check($sformatf("row%0d rs_valid", i), 256'(rs_valid), 256'(e_rsv));
      check($sformatf("row%0d rs_uop", i), 256'(rs_uop), 256'(e_rs));
      check($sformatf("row%0d lsq_valid", i), 256'(lsq_valid), 256'(e_lqv));
      check($sformatf("row%0d lsq_uop", i), 256'(lsq_uop), 256'(e_lq));
      @(posedge clk); #1;
    end

    // Enqueue-to-dispatch latency on an empty FIFO
    drive(1'b0, 1'b0, 1'b1, 8'h30, 1'b0, 64, 40, 2, 2);
    #2;
    check("lat same-cycle rs_valid", 256'(rs_valid), 256'(BYP));
    check("lat same-cycle occupancy", 256'(occupancy), 256'(0));
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 64, 41, 2, 2);
    #2;
    check("lat next rs_valid", 256'(rs_valid), 256'(1 - BYP));
    check("lat next occupancy", 256'(occupancy), 256'(1 - BYP));
    @(posedge clk); #1;

    // Reset takes priority over flush and enqueue
    drive(1'b0, 1'b0, 1'b1, 8'h40, 1'b0, 64, 0, 0, 0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b1, 8'h41, 1'b0, 64, 0, 0, 0);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b1, 8'h42, 1'b0, 64, 0, 2, 2);
    #2;
    check("rst occupancy before", 256'(occupancy), 256'(2));
    check("rst in_ready", 256'(in_ready), 256'(0));
    check("rst rob_alloc_count", 256'(rob_alloc_count), 256'(0));
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 64, 0, 2, 2);
    #2;
    check("post-rst occupancy", 256'(occupancy), 256'(0));
    check("post-rst in_ready", 256'(in_ready), 256'(1));
    check("post-rst rob_alloc_count", 256'(rob_alloc_count), 256'(0));
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
